imem_loader_ctl: RTL
====================

Name: imem_loader_ctl

Overview:
- Run controller and instruction-memory owner for `processor`.
- Holds the 1024x16 program store, loads it from a little-endian byte stream, and serves fetches on `pc`.
- Holds the core in reset while not running, and stops the run on halt pin or PC overrun.
- Replaces the bench-side file load, byteswap and run/terminate loop with synthesizable sequencing.

Parameters:
- ADDR_W, 10, program store address width.
- PROG_WORDS, 1024, store depth; must be ≤ 2**ADDR_W.
- PC_W, 16, width of the core PC (`BITNESS`).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ld_start  in  1  one-cycle request to begin a load
- ld_len  in  ADDR_W+1  words to load, latched on accepted ld_start
- ld_byte  in  8  stream byte, low byte of each word first
- ld_valid  in  1  ld_byte valid
- ld_ready  out  1  controller accepts a byte this cycle
- run_start  in  1  one-cycle request to (re)run the loaded image
- pc  in  PC_W  core program counter
- ins  out  16  fetched instruction to core
- halt_pin  in  1  core halt output (pin_out[1])
- core_rst  out  1  active-high reset to core
- state  out  3  IDLE=0, LOAD=1, RUN=2, HALT=3, FAULT=4
- fault_code  out  2  0 none, 1 bad length, 2 PC overrun, 3 checksum
- run_cycles  out  32  cycles spent in current/last RUN
- ld_csum  out  16  running load checksum

Behaviour:
- Reset (rst low, async) forces the following:
  - State and outputs: state=IDLE, ld_ready=0, core_rst=1, fault_code=0, run_cycles=0, ld_csum=0.
  - Internal registers: loaded=0, wptr=0, byte phase=0.
  - Memory contents are not cleared.
- Reset asserted mid-LOAD aborts the load. loaded=0, so run_start is ignored until a full load completes.
- core_rst is registered: core_rst=0 exactly while state==RUN, and 1 in all other states. Release is therefore the cycle after entry into RUN.
- ins = mem[pc[ADDR_W-1:0]] combinationally while state==RUN; ins=16'h0 otherwise.
- IDLE:
  - ld_start with 1 ≤ ld_len ≤ PROG_WORDS → LOAD; latch len, wptr=0, phase=0, ld_csum=0.
  - ld_start with ld_len=0 or ld_len>PROG_WORDS → FAULT, fault_code=1.
  - run_start with loaded=1 → RUN; otherwise run_start is ignored.
  - ld_start has priority over run_start when both arrive in the same cycle.
- LOAD:
  - ld_ready=1 and registered, so it is first high the cycle after entry. A byte is accepted when ld_valid&&ld_ready.
  - phase 0: latch the low byte into a holding register.
  - phase 1: write {ld_byte, low} to mem[wptr]; ld_csum += word (mod 2^16); wptr++.
  - After the write of word len-1: loaded=1, state → RUN next cycle, and ld_ready drops that cycle.
  - ld_start and run_start are ignored in LOAD. ld_valid gaps stall without loss.
- RUN:
  - run_cycles is cleared on entry, then increments each RUN cycle and saturates at 32'hFFFFFFFF.
  - The following are evaluated each cycle:
    - halt_pin=1 → HALT.
    - Otherwise, if pc ≥ latched len, → FAULT with fault_code=2.
    - halt_pin has priority over overrun in the same cycle.
  - ld_start and run_start are ignored in RUN.
- HALT:
  - run_cycles is held.
  - ld_start behaves as in IDLE (including the bad-length fault).
  - run_start → RUN; the core restarts from its reset PC because core_rst was high.
- FAULT:
  - Sticky; fault_code and run_cycles are held.
  - Only a valid ld_start (→ LOAD, fault_code cleared) or reset exits. run_start is ignored.
  - Any FAULT entry clears loaded.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined:
  - After the last word, LOAD accepts two further bytes: the expected checksum, low byte first.
  - Match → RUN with loaded=1.
  - Mismatch → FAULT, fault_code=3, loaded=0.
  - ld_csum shows the computed sum.
- Undefined:
  - No trailer bytes are taken; LOAD → RUN directly after the last word.
  - ld_csum is tied to 16'h0.
  - fault_code=3 never occurs.

Test Plan:
- Reset, ld_start with ld_len=2, bytes 34 12 CD AB → mem[0]=16'h1234, mem[1]=16'hABCD, RUN entered, core_rst low one cycle later, ins=16'h1234 with pc=0.
- ld_start with ld_len=0, then with ld_len=1025 → FAULT, fault_code=1, ld_ready stays 0; a following run_start is ignored.
- 16-word load, core driven so pc reaches 16 with halt_pin=0 → FAULT with fault_code=2 the next cycle, core_rst=1, ins=0.
- RUN for 7 cycles then halt_pin=1 → HALT, run_cycles=7; run_start → RUN, run_cycles restarts at 0.
- Byte stream with ld_valid toggling every other cycle, plus rst pulsed low after 3 bytes → state=IDLE immediately; run_start ignored; a full reload succeeds.
- IMEM_CHECKSUM_EN defined, words 0001 and 0002 with trailer 03 00 → RUN. Same words with trailer 04 00 → FAULT, fault_code=3, ld_csum=16'h0003.

Source files
------------

// File: rtl/imem_loader_ctl.sv
// Run controller and 1024x16 instruction store: loads a little-endian byte stream, serves fetches, sequences core reset.
// Optional macro IMEM_CHECKSUM_EN: LOAD expects a 2-byte checksum trailer after the last word.
module imem_loader_ctl #(
  parameter int ADDR_W     = 10,
  parameter int PROG_WORDS = 1024,
  parameter int PC_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              run_start,
  input  logic [PC_W-1:0]   pc,
  output logic [15:0]       ins,
  input  logic              halt_pin,
  output logic              core_rst,
  output logic [2:0]        state,
  output logic [1:0]        fault_code,
  output logic [31:0]       run_cycles,
  output logic [15:0]       ld_csum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(PROG_WORDS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  localparam int CMP_W = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;

  state_t            state_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   wptr_reg;
  logic              phase_reg;
  logic [7:0]        low_reg;
  logic              loaded_reg;
  logic              ld_ready_reg;
  logic              core_rst_reg;
  logic [1:0]        fault_reg;
  logic [31:0]       cycles_reg;

  logic [15:0] mem [PROG_WORDS];

  logic [15:0]      word;
  logic             len_ok;
  logic             overrun;
  logic             mem_we;
  logic [CMP_W-1:0] pc_ext;
  logic [CMP_W-1:0] len_ext;

  assign word    = {ld_byte, low_reg};
  assign len_ok  = (ld_len != '0) && (ld_len <= MAX_LEN);
  assign pc_ext  = CMP_W'(pc);
  assign len_ext = CMP_W'(len_reg);
  assign overrun = (pc_ext >= len_ext);
  // Second byte of a data word (trailer bytes never reach the store).
  assign mem_we  = (state_reg == S_LOAD) && ld_valid && ld_ready_reg && phase_reg && (wptr_reg != len_reg);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_reg[ADDR_W-1:0]] <= word;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [15:0] csum_reg;
  assign ld_csum = csum_reg;
`else
  assign ld_csum = 16'h0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      wptr_reg     <= '0;
      phase_reg    <= 1'b0;
      low_reg      <= 8'h0;
      loaded_reg   <= 1'b0;
      ld_ready_reg <= 1'b0;
      core_rst_reg <= 1'b1;
      fault_reg    <= 2'd0;
      cycles_reg   <= 32'd0;
`ifdef IMEM_CHECKSUM_EN
      csum_reg     <= 16'h0;
`endif
    end else begin
      ld_ready_reg <= 1'b0;
      core_rst_reg <= 1'b1;
      case (state_reg)
        S_IDLE, S_HALT, S_FAULT: begin
          if (ld_start && len_ok) begin
            state_reg    <= S_LOAD;
            len_reg      <= ld_len;
            wptr_reg     <= '0;
            phase_reg    <= 1'b0;
            fault_reg    <= 2'd0;
            ld_ready_reg <= 1'b1;
`ifdef IMEM_CHECKSUM_EN
            csum_reg     <= 16'h0;
`endif
          end else if (ld_start && (state_reg != S_FAULT)) begin
            state_reg  <= S_FAULT;
            fault_reg  <= 2'd1;
            loaded_reg <= 1'b0;
          end else if (run_start && ((state_reg == S_HALT) || ((state_reg == S_IDLE) && loaded_reg))) begin
            state_reg  <= S_RUN;
            cycles_reg <= 32'd0;
          end
        end
        S_LOAD: begin
          ld_ready_reg <= 1'b1;
          if (ld_valid && ld_ready_reg) begin
            phase_reg <= ~phase_reg;
            if (!phase_reg) begin
              low_reg <= ld_byte;
            end else begin
`ifdef IMEM_CHECKSUM_EN
              if (wptr_reg != len_reg) begin
                wptr_reg <= wptr_reg + ONE;
                csum_reg <= csum_reg + word;
              end else if (word == csum_reg) begin
                state_reg    <= S_RUN;
                loaded_reg   <= 1'b1;
                cycles_reg   <= 32'd0;
                ld_ready_reg <= 1'b0;
              end else begin
                state_reg    <= S_FAULT;
                fault_reg    <= 2'd3;
                loaded_reg   <= 1'b0;
                ld_ready_reg <= 1'b0;
              end
`else
              wptr_reg <= wptr_reg + ONE;
              if (wptr_reg == len_reg - ONE) begin
                state_reg    <= S_RUN;
                loaded_reg   <= 1'b1;
                cycles_reg   <= 32'd0;
                ld_ready_reg <= 1'b0;
              end
`endif
            end
          end
        end
        S_RUN: begin
          if (cycles_reg != 32'hFFFF_FFFF) begin
            cycles_reg <= cycles_reg + 32'd1;
          end
          // Core reset stays released only while RUN continues into the next cycle.
          if (halt_pin) begin
            state_reg <= S_HALT;
          end else if (overrun) begin
            state_reg  <= S_FAULT;
            fault_reg  <= 2'd2;
            loaded_reg <= 1'b0;
          end else begin
            core_rst_reg <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ld_ready   = ld_ready_reg;
  assign core_rst   = core_rst_reg;
  assign state      = state_reg;
  assign fault_code = fault_reg;
  assign run_cycles = cycles_reg;
  assign ins        = (state_reg == S_RUN) ? mem[pc[ADDR_W-1:0]] : 16'h0;

endmodule
